// File: rtl/tile_map_controller.sv
// 15x20 wall-tile map: reloaded row-by-row from an external level ROM, with
// rocket tile-clear requests queued in a small FIFO and applied between frames.
module tile_map_controller (
  input  logic        clk,
  input  logic        resetN,
  input  logic [1:0]  level_sel,
  input  logic        load_req,
  output logic [1:0]  rom_level,
  output logic [3:0]  rom_row,
  input  logic [19:0] rom_data,
  input  logic        req1_valid,
  input  logic [3:0]  req1_row,
  input  logic [4:0]  req1_col,
  output logic        req1_ready,
  input  logic        req2_valid,
  input  logic [3:0]  req2_row,
  input  logic [4:0]  req2_col,
  output logic        req2_ready,
  input  logic        start_of_frame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic        tile_on,
  output logic [8:0]  tiles_left,
  output logic        busy,
  output logic        level_clear
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int unsigned ROWS  = 15;
  localparam int unsigned COLS  = 20;
  localparam int unsigned DEPTH = 4;

  logic [1:0]      state_q, state_d;
  logic [3:0]      row_q, row_d;
  logic [1:0]      level_q, level_d;
  logic [8:0]      tiles_q, tiles_d;
  logic            clear_q, clear_d;
  logic            prio2_q, prio2_d;
  logic [COLS-1:0] map_q [ROWS];
  logic [COLS-1:0] map_d [ROWS];
  logic [8:0]      fifo_q [DEPTH];
  logic [8:0]      fifo_d [DEPTH];
  logic [1:0]      wr_q, wr_d;
  logic [1:0]      rd_q, rd_d;
  logic [2:0]      cnt_q, cnt_d;

  logic       reload;
  logic       can_push;
  logic       grant1;
  logic       grant2;
  logic       accept;
  logic       push;
  logic       pop;
  logic       pop_hit;
  logic [3:0] acc_row;
  logic [4:0] acc_col;
  logic [3:0] pop_row;
  logic [4:0] pop_col;
  logic       in_view;

  function automatic logic [4:0] popcount20(input logic [19:0] v);
    logic [4:0] n;
    n = '0;
    for (int unsigned i = 0; i < 20; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  // A reload request wins over everything else in the same cycle, so the
  // readies are held low then rather than accepting a request about to be flushed.
  always_comb begin
    reload     = load_req && (state_q != ST_LOAD);
    can_push   = (state_q != ST_LOAD) && !reload && (cnt_q != 3'd4);
    grant1     = req1_valid && (!req2_valid || !prio2_q);
    grant2     = req2_valid && (!req1_valid || prio2_q);
    req1_ready = can_push && grant1;
    req2_ready = can_push && grant2;
    accept     = req1_ready || req2_ready;
    acc_row    = grant1 ? req1_row : req2_row;
    acc_col    = grant1 ? req1_col : req2_col;
    push       = accept && (acc_row <= 4'd14) && (acc_col <= 5'd19);
    pop        = (state_q == ST_DRAIN) && (cnt_q != 3'd0) && !reload;
    pop_row    = fifo_q[rd_q][8:5];
    pop_col    = fifo_q[rd_q][4:0];
    pop_hit    = map_q[pop_row][pop_col];
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    level_d = level_q;
    tiles_d = tiles_q;
    clear_d = 1'b0;
    prio2_d = prio2_q;
    map_d   = map_q;
    fifo_d  = fifo_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;

    if (accept) prio2_d = grant1;

    if (push) begin
      fifo_d[wr_q] = {acc_row, acc_col};
      wr_d         = wr_q + 2'd1;
    end
    if (pop) rd_d = rd_q + 2'd1;
    if (push && !pop)      cnt_d = cnt_q + 3'd1;
    else if (pop && !push) cnt_d = cnt_q - 3'd1;

    case (state_q)
      ST_LOAD: begin
        map_d[row_q] = rom_data;
        tiles_d      = tiles_q + 9'(popcount20(rom_data));
        row_d        = row_q + 4'd1;
        if (row_q == 4'd14) begin
          row_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (start_of_frame && (cnt_q != 3'd0)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop) begin
          map_d[pop_row][pop_col] = 1'b0;
          if (pop_hit) begin
            tiles_d = tiles_q - 9'd1;
            clear_d = (tiles_q == 9'd1);
          end
        end
        if (cnt_d == 3'd0) state_d = ST_RUN;
      end
      default: state_d = ST_LOAD;
    endcase

    if (reload) begin
      state_d = ST_LOAD;
      level_d = level_sel;
      row_d   = '0;
      tiles_d = '0;
      clear_d = 1'b0;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_LOAD;
      row_q   <= '0;
      level_q <= '0;
      tiles_q <= '0;
      clear_q <= 1'b0;
      prio2_q <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      for (int unsigned r = 0; r < ROWS; r++) map_q[r] <= '0;
      for (int unsigned e = 0; e < DEPTH; e++) fifo_q[e] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      level_q <= level_d;
      tiles_q <= tiles_d;
      clear_q <= clear_d;
      prio2_q <= prio2_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      map_q   <= map_d;
      fifo_q  <= fifo_d;
    end
  end

  always_comb begin
    in_view = (pixelX < 11'd640) && (pixelY < 11'd480);
    tile_on = (state_q != ST_LOAD) && in_view && map_q[pixelY[8:5]][pixelX[9:5]];
  end

  assign rom_level   = level_q;
  assign rom_row     = row_q;
  assign tiles_left  = tiles_q;
  assign busy        = (state_q == ST_LOAD);
  assign level_clear = clear_q;

endmodule

// File: tb/tb_tile_map_controller.sv
// Directed bench for tile_map_controller with a small behavioural level ROM.
module tb_tile_map_controller;

  logic        clk = 1'b0;
  logic        resetN;
  logic [1:0]  level_sel;
  logic        load_req;
  logic [1:0]  rom_level;
  logic [3:0]  rom_row;
  logic [19:0] rom_data;
  logic        req1_valid, req2_valid;
  logic [3:0]  req1_row, req2_row;
  logic [4:0]  req1_col, req2_col;
  logic        req1_ready, req2_ready;
  logic        start_of_frame;
  logic [10:0] pixelX, pixelY;
  logic        tile_on;
  logic [8:0]  tiles_left;
  logic        busy;
  logic        level_clear;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  tile_map_controller dut (
    .clk(clk), .resetN(resetN), .level_sel(level_sel), .load_req(load_req),
    .rom_level(rom_level), .rom_row(rom_row), .rom_data(rom_data),
    .req1_valid(req1_valid), .req1_row(req1_row), .req1_col(req1_col), .req1_ready(req1_ready),
    .req2_valid(req2_valid), .req2_row(req2_row), .req2_col(req2_col), .req2_ready(req2_ready),
    .start_of_frame(start_of_frame), .pixelX(pixelX), .pixelY(pixelY),
    .tile_on(tile_on), .tiles_left(tiles_left), .busy(busy), .level_clear(level_clear)
  );

  // Level 0: full (300), level 1: only row 14 col 19 (1), level 2: cols 0..3 (60), level 3: empty.
  always_comb begin
    case (rom_level)
      2'd0:    rom_data = 20'hFFFFF;
      2'd1:    rom_data = (rom_row == 4'd14) ? 20'h80000 : 20'h00000;
      2'd2:    rom_data = 20'h0000F;
      default: rom_data = 20'h00000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
    #1;
  endtask

  task automatic load_wait(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    check(tag, n, exp_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] exp_r1;
    logic [5:0] exp_r2;
    int pulses;

    resetN = 1'b0; level_sel = '0; load_req = 1'b0; start_of_frame = 1'b0;
    req1_valid = 1'b0; req1_row = '0; req1_col = '0;
    req2_valid = 1'b0; req2_row = '0; req2_col = '0;
    pixelX = '0; pixelY = '0;
    step(); step();

    // Reset state
    check("rst_busy", busy, 1);
    check("rst_tiles", tiles_left, 0);
    check("rst_rom_row", rom_row, 0);
    check("rst_rom_level", rom_level, 0);
    check("rst_level_clear", level_clear, 0);
    pix(0, 0);
    check("rst_tile_on", tile_on, 0);
    req1_valid = 1'b1; #1;
    check("rst_req1_ready", req1_ready, 0);
    req1_valid = 1'b0;

    // Level 0 load after reset release
    resetN = 1'b1;
    load_wait("load0_cycles", 15);
    check("load0_tiles", tiles_left, 300);
    pix(0, 0);     check("tile_0_0", tile_on, 1);
    pix(639, 479); check("tile_639_479", tile_on, 1);
    pix(640, 0);   check("tile_640_0", tile_on, 0);
    pix(0, 480);   check("tile_0_480", tile_on, 0);

    // Single clear waits for start_of_frame
    req1_valid = 1'b1; req1_row = 4'd2; req1_col = 5'd3; #1;
    check("r034_ready1", req1_ready, 1);
    check("r034_ready2", req2_ready, 0);
    step();
    req1_valid = 1'b0;
    pix(96, 64);
    repeat (100) step();
    check("r034_hold_tile", tile_on, 1);
    check("r034_hold_tiles", tiles_left, 300);
    start_of_frame = 1'b1;
    step();
    start_of_frame = 1'b0; #1;
    check("r034_drain_entry_tile", tile_on, 1);
    step();
    check("r034_cleared_tile", tile_on, 0);
    check("r034_cleared_tiles", tiles_left, 299);
    pix(128, 64);
    check("r034_neighbour_tile", tile_on, 1);

    // Fresh reset, then round-robin arbitration until full
    resetN = 1'b0; step(); resetN = 1'b1;
    load_wait("load0b_cycles", 15);
    check("load0b_tiles", tiles_left, 300);
    req1_valid = 1'b1; req1_row = 4'd0; req1_col = 5'd0;
    req2_valid = 1'b1; req2_row = 4'd0; req2_col = 5'd1;
    exp_r1 = 6'b000101;
    exp_r2 = 6'b001010;
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr_ready1_c%0d", i), req1_ready, exp_r1[i]);
      check($sformatf("rr_ready2_c%0d", i), req2_ready, exp_r2[i]);
      step();
    end
    req1_valid = 1'b0; req2_valid = 1'b0;
    start_of_frame = 1'b1;
    step();
    start_of_frame = 1'b0;
    req1_valid = 1'b1; req1_row = 4'd5; req1_col = 5'd5; #1;
    check("full_during_pop", req1_ready, 0);
    step();
    check("drain1_tiles", tiles_left, 299);
    check("push_with_pop_ready", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    check("drain2_tiles", tiles_left, 298);
    step();
    check("dup_clear_tiles", tiles_left, 298);
    step();
    pix(160, 160);
    check("pushed_pending_tile", tile_on, 1);
    step();
    check("pushed_cleared_tile", tile_on, 0);
    check("drain_end_tiles", tiles_left, 297);
    pix(32, 0);
    check("col1_cleared_tile", tile_on, 0);
    check("no_level_clear", level_clear, 0);

    // Out-of-range request consumed but not queued
    req2_valid = 1'b1; req2_row = 4'd15; req2_col = 5'd7; #1;
    check("oor_ready2", req2_ready, 1);
    step();
    req2_valid = 1'b0;
    check("oor_tiles", tiles_left, 297);
    req1_valid = 1'b1; req1_row = 4'd0;
    for (int i = 0; i < 4; i++) begin
      req1_col = 5'(2 + i); #1;
      check($sformatf("fill_ready1_%0d", i), req1_ready, 1);
      step();
    end
    #1;
    check("fifo_full_after_4", req1_ready, 0);
    req1_valid = 1'b0;

    // Reload during DRAIN with 3 entries pending
    start_of_frame = 1'b1;
    step();
    start_of_frame = 1'b0;
    step();
    check("pre_reload_tiles", tiles_left, 296);
    pix(64, 0);
    check("pre_reload_tile", tile_on, 0);
    load_req = 1'b1; level_sel = 2'd2;
    step();
    load_req = 1'b0;
    check("reload_busy", busy, 1);
    check("reload_rom_level", rom_level, 2);
    check("reload_rom_row", rom_row, 0);
    check("reload_tiles_cleared", tiles_left, 0);
    step(); step();
    load_req = 1'b1; level_sel = 2'd1;
    step();
    load_req = 1'b0;
    check("load_req_ignored", rom_level, 2);
    load_wait("reload_rest_cycles", 12);
    check("level2_tiles", tiles_left, 60);
    pix(96, 0);
    check("pending_discarded_tile", tile_on, 1);
    pix(128, 0);
    check("level2_col4_tile", tile_on, 0);
    start_of_frame = 1'b1;
    step();
    start_of_frame = 1'b0;
    step(); step();
    pix(96, 0);
    check("post_flush_tile", tile_on, 1);
    check("post_flush_tiles", tiles_left, 60);
    check("post_flush_busy", busy, 0);

    // Single-tile level cleared twice
    load_req = 1'b1; level_sel = 2'd1;
    step();
    load_req = 1'b0;
    load_wait("load1_cycles", 15);
    check("level1_tiles", tiles_left, 1);
    pix(639, 479);
    check("level1_tile", tile_on, 1);
    req1_valid = 1'b1; req1_row = 4'd14; req1_col = 5'd19; #1;
    check("dup1_ready", req1_ready, 1);
    step();
    check("dup2_ready", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    start_of_frame = 1'b1;
    step();
    start_of_frame = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (level_clear === 1'b1) pulses++;
    end
    check("level_clear_pulses", pulses, 1);
    check("level1_cleared_tiles", tiles_left, 0);
    check("level1_cleared_tile", tile_on, 0);
    check("level1_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_map_controller.md
TILE_MAP_CONTROLLER -- requirements
Module: tile_map_controller

Interface
REQ-001 SHALL: clk  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL: resetN  in  1  asynchronous, active-low reset.
REQ-003 SHALL: level_sel  in  2  level to load on load_req.
REQ-004 SHALL: load_req  in  1  one-cycle pulse; starts a map reload.
REQ-005 SHALL: rom_level  out  2  level index presented to the external level ROM.
REQ-006 SHALL: rom_row  out  4  row index (0..14) presented to the ROM.
REQ-007 SHALL: rom_data  in  20  ROM row bits, combinational from rom_level/rom_row; bit c = column c.
REQ-008 SHALL: req1_valid / req2_valid  in  1  rocket 1 / rocket 2 tile-clear request.
REQ-009 SHALL: req1_row, req2_row  in  4; req1_col, req2_col  in  5  tile coordinates of the request.
REQ-010 SHALL: req1_ready / req2_ready  out  1  request accepted this cycle (valid && ready).
REQ-011 SHALL: start_of_frame  in  1  one-cycle pulse at frame start.
REQ-012 SHALL: pixelX, pixelY  in  11  current pixel coordinates.
REQ-013 SHALL: tile_on  out  1  wall present at the current pixel (combinational).
REQ-014 SHALL: tiles_left  out  9  count of set tiles (0..300).
REQ-015 SHALL: busy  out  1  high in LOAD state.
REQ-016 SHALL: level_clear  out  1  one-cycle pulse when tiles_left becomes 0.

Function
REQ-017 SHALL hold a 15x20 bit map; FSM states LOAD, RUN, DRAIN.
REQ-018 LOAD SHALL copy rom_data into map row rom_row, one row per cycle, rows 0..14 (15 cycles), then enter RUN; rom_level holds the latched level.
REQ-019 In LOAD, tiles_left SHALL be cleared on entry and accumulate popcount(rom_data) each cycle; its final value SHALL equal total set bits of the level.
REQ-020 load_req in RUN or DRAIN SHALL latch level_sel, flush the FIFO, and enter LOAD next cycle; load_req in LOAD SHALL be ignored.
REQ-021 A 4-entry clear FIFO SHALL hold accepted {row,col} requests.
REQ-022 reqN_ready SHALL be high only when state != LOAD, FIFO not full, and requester N holds the grant.
REQ-023 Arbitration SHALL be round-robin: with one valid requester it is granted; with both valid, the one not granted last time wins; at most one push per cycle.
REQ-024 Accepted requests with row > 14 or col > 19 SHALL be consumed (ready high) but not enqueued.
REQ-025 Map clears SHALL apply only in DRAIN; start_of_frame in RUN with FIFO non-empty SHALL enter DRAIN next cycle; RUN SHALL never modify the map.
REQ-026 DRAIN SHALL pop one entry per cycle and clear that map bit, visible on tile_on the next cycle; when FIFO becomes empty, return to RUN.
REQ-027 Push and pop SHALL be allowed in the same cycle; when full, no push occurs even if a pop occurs that cycle.
REQ-028 tiles_left SHALL decrement by 1 only when the popped bit was 1; clearing an already-clear tile SHALL change nothing.
REQ-029 level_clear SHALL pulse for one cycle on the 1->0 transition of tiles_left in DRAIN; never in LOAD.
REQ-030 tile_on SHALL equal map[pixelY/32][pixelX/32] when pixelX < 640 and pixelY < 480, else 0; it SHALL be 0 in LOAD.

Reset
REQ-031 On resetN low: map all 0, FIFO empty, tiles_left 0, latched level 0, arbiter grant to requester 1, level_clear 0, readies 0.
REQ-032 On release, state SHALL be LOAD at row 0 with level 0 (busy 1); reset mid-LOAD or mid-DRAIN SHALL abort immediately to this state.

Verification
REQ-033 Reset release, ROM level 0 rows all 0xFFFFF -> busy 1 for 15 cycles, then tiles_left = 300, tile_on = 1 at (0,0) and (639,479), 0 at (640,0).
REQ-034 RUN, req1 (row 2, col 3) accepted, no start_of_frame for 100 cycles -> tile_on at (96,64) stays 1; after start_of_frame, 0 two cycles later, tiles_left 299.
REQ-035 Both requests valid for 6 cycles, no frame pulse -> grants alternate 1,2,1,2, then both readies 0 (FIFO full).
REQ-036 Map with a single set tile (row 14, col 19), clear it twice -> tiles_left 1 -> 0, exactly one level_clear pulse.
REQ-037 req2 with row 15, col 7 -> ready 1, FIFO unchanged, map unchanged.
REQ-038 load_req with level_sel 2 during DRAIN with 3 entries pending -> FIFO flushed, rom_level = 2, 15-cycle LOAD, pending clears discarded.
